// File: rtl/hs_npu_result_drain.sv
// Drains complete rows from the NPU output FIFOs and writes them to memory as bus-width beats.
// Optional define HS_NPU_RESULT_DRAIN_LANE_CHECK_EN adds a sticky lane_err_o for stuck partial rows.
module hs_npu_result_drain #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           num_rows_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic [DATA_WIDTH-1:0] row_i [SIZE],
    input  logic [SIZE-1:0]       row_valid_i,
    output logic                  row_ready_o,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [BUS_WIDTH-1:0]  wr_data_o
`ifdef HS_NPU_RESULT_DRAIN_LANE_CHECK_EN
    ,
    output logic                  lane_err_o
`endif
);

    localparam int EPB    = BUS_WIDTH / DATA_WIDTH;
    localparam int BEATS  = SIZE * DATA_WIDTH / BUS_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ROW = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           rows_q;
    logic [15:0]           row_cnt_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [BUS_WIDTH-1:0]  beat_buf [BEATS];

    logic start_acc;
    logic wr_fire;
    logic last_beat;

    assign start_acc = (state_q == IDLE) && start_i;
    assign wr_fire   = wr_valid_o && wr_ready_i;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = (state_q != IDLE);
        done_o      = 1'b0;
        row_ready_o = 1'b0;
        wr_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_rows_i == 16'd0) ? DONE : WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                row_ready_o = &row_valid_i;
                if (row_ready_o) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_valid_o = 1'b1;
                if (wr_ready_i && last_beat) begin
                    state_d = ((row_cnt_q + 16'd1) == rows_q) ? DONE : WAIT_ROW;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Row buffer is held in beat order so the write path is a plain index by beat_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            rows_q    <= '0;
            row_cnt_q <= '0;
            beat_q    <= '0;
            for (int k = 0; k < BEATS; k++) begin
                beat_buf[k] <= '0;
            end
        end else begin
            if (start_acc) begin
                addr_q    <= base_addr_i;
                rows_q    <= num_rows_i;
                row_cnt_q <= '0;
            end
            if (row_ready_o) begin
                beat_q <= '0;
                for (int k = 0; k < BEATS; k++) begin
                    for (int e = 0; e < EPB; e++) begin
                        beat_buf[k][e*DATA_WIDTH +: DATA_WIDTH] <= row_i[k*EPB + e];
                    end
                end
            end
            if (wr_fire) begin
                addr_q <= addr_q + ADDR_WIDTH'(BUS_WIDTH / 8);
                beat_q <= last_beat ? '0 : beat_q + 1'b1;
                if (last_beat) begin
                    row_cnt_q <= row_cnt_q + 16'd1;
                end
            end
        end
    end

    assign wr_addr_o = addr_q;
    assign wr_data_o = (state_q == WRITE) ? beat_buf[beat_q] : '0;

`ifdef HS_NPU_RESULT_DRAIN_LANE_CHECK_EN
    logic [4:0] lane_cnt_q;
    logic       partial_row;

    assign partial_row = (state_q == WAIT_ROW) && (|row_valid_i) && !(&row_valid_i);

    // Counter saturates at 16; the flag latches on the 16th consecutive partial cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_q <= '0;
            lane_err_o <= 1'b0;
        end else begin
            if (partial_row) begin
                if (lane_cnt_q != 5'd16) begin
                    lane_cnt_q <= lane_cnt_q + 5'd1;
                end
                if (lane_cnt_q == 5'd15) begin
                    lane_err_o <= 1'b1;
                end
            end else begin
                lane_cnt_q <= '0;
            end
            if (start_acc) begin
                lane_err_o <= 1'b0;
            end
        end
    end
`endif

endmodule
